// File: rtl/cdc_hs_src_ctrl.sv
// Source side of a toggle-handshake event crossing: queues event pulses and launches
// them one at a time by flipping req_tog, waiting for the synchronized ack toggle in between.
module cdc_hs_src_ctrl #(
   parameter int CNT_W   = 4,
   parameter int TIMEOUT = 64,
   parameter int TMR_W   = 8
) (
   input  logic             clock,
   input  logic             arst_n,
   input  logic             evt,
   input  logic             clr_err,
   input  logic             ack_sync,
   output logic             req_tog,
   output logic             busy,
   output logic [CNT_W-1:0] pending,
   output logic             ovf_err,
   output logic             tmo_err
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      ERROR    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam bit               TMO_EN   = (TIMEOUT != 0);

   state_t           state;
   state_t           state_nxt;
   logic [TMR_W-1:0] timer;
   logic [TMR_W-1:0] timer_nxt;
   logic [CNT_W-1:0] pending_nxt;
   logic             req_nxt;
   logic             ovf_nxt;
   logic             tmo_nxt;
   logic             launch;
   logic             accept;
   logic             ovf_set;
   logic             tmo_set;
   logic             ack_match;

   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      req_nxt     = req_tog;
      launch      = 1'b0;
      tmo_set     = 1'b0;
      ack_match   = (ack_sync == req_tog);

      case (state)
         IDLE: begin
            if (pending != '0) begin
               launch    = 1'b1;
               req_nxt   = ~req_tog;
               timer_nxt = '0;
               state_nxt = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            // A match arriving on the final timeout cycle takes priority over the error.
            if (ack_match) begin
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer + 1'b1;
               if (TMO_EN && (timer == TMO_LAST)) begin
                  tmo_set   = 1'b1;
                  state_nxt = ERROR;
               end
            end
         end
         ERROR: begin
            if (clr_err && ack_match) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // A launch frees a slot, so a saturated counter can still take an event on that edge.
      accept  = evt && ((pending != CNT_MAX) || launch);
      ovf_set = evt && !accept;

      pending_nxt = pending;
      if (accept && !launch) begin
         pending_nxt = pending + 1'b1;
      end else if (!accept && launch) begin
         pending_nxt = pending - 1'b1;
      end

      ovf_nxt = ovf_set | (ovf_err & ~clr_err);
      tmo_nxt = tmo_set | (tmo_err & ~clr_err);
   end

   always_ff @(posedge clock) begin
      if (!arst_n) begin
         state   <= IDLE;
         timer   <= '0;
         req_tog <= 1'b0;
         pending <= '0;
         busy    <= 1'b0;
         ovf_err <= 1'b0;
         tmo_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         req_tog <= req_nxt;
         pending <= pending_nxt;
         busy    <= (state_nxt != IDLE);
         ovf_err <= ovf_nxt;
         tmo_err <= tmo_nxt;
      end
   end

endmodule

// File: doc/cdc_hs_src_ctrl.md
Name: cdc_hs_src_ctrl

Overview:
Source-side controller for a toggle-handshake event crossing built on the team's synchronizer cells. It queues event pulses in a pending counter and launches one event at a time by flipping a request toggle. That toggle feeds the din of a forward synchronizer. The controller then waits for the destination's acknowledge toggle, which returns through a reverse synchronizer, before launching the next event. Overflow and acknowledge-timeout are flagged with sticky, clearable error bits.

Parameters:
CNT_W, 4, width of pending-event counter; max queued events = 2^CNT_W-1
TIMEOUT, 64, cycles allowed in WAIT_ACK before timeout error; 0 disables timeout
TMR_W, 8, timer width; must satisfy 2^TMR_W > TIMEOUT

Ports:
clock  input  1  single clock; all logic in this domain
arst_n  input  1  reset, synchronous, active low; sampled on rising edge of clock only
evt  input  1  one event per cycle when high
clr_err  input  1  clears sticky error flags; exits ERROR (see below)
ack_sync  input  1  acknowledge toggle from destination, already synchronized into clock (reverse synchronizer dout)
req_tog  output  1  request toggle; drives forward synchronizer din; registered, glitch-free
busy  output  1  high when state != IDLE
pending  output  CNT_W  queued, not-yet-launched events
ovf_err  output  1  sticky: event dropped because pending was saturated
tmo_err  output  1  sticky: ack not received within TIMEOUT cycles

Behaviour:
- Reset (arst_n=0 at rising edge): state=IDLE; req_tog=0; pending=0; timer=0; busy=0; ovf_err=0; tmo_err=0. The destination must also reset so that ack_sync=0.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, WAIT_ACK, ERROR.
- IDLE with registered pending!=0: on that edge, req_tog flips, pending decrements, timer clears, state goes to WAIT_ACK.
- IDLE with pending==0: hold.
- WAIT_ACK, ack_sync==req_tog: on that edge, state goes to IDLE. The earliest next launch is the following edge, so there is at least one IDLE cycle between launches.
- WAIT_ACK otherwise: timer increments.
  - If TIMEOUT!=0 and timer==TIMEOUT-1 with no match: tmo_err=1 and state goes to ERROR on that edge.
  - If ack matches on that same cycle, the match wins: go to IDLE, no error.
- ERROR: no launches; pending keeps accepting events. Exit to IDLE on the edge where clr_err=1 and ack_sync==req_tog. If clr_err=1 while they still differ, clear the flags but remain in ERROR.
- Pending counter update, each edge: next = pending + (evt accepted) - (launch).
  - Simultaneous evt and launch: pending unchanged.
  - Saturated (2^CNT_W-1) with evt and no launch: event dropped, ovf_err=1, pending held.
  - Saturated with evt and launch: accepted, count unchanged.
- Latency: evt high at edge N gives pending=1 after N. If the block is IDLE, req_tog flips after edge N+1 and busy=1 after N+1.
- clr_err and a new error condition on the same edge: the set wins, and the flag stays 1.
- req_tog changes at most once per handshake. It never changes in WAIT_ACK or ERROR.
- Reset mid-handshake: everything returns to reset values immediately. Any in-flight event is lost; that is the system's responsibility.
- ack_sync toggling while IDLE (spurious): ignored. The state check uses equality only.

Test Plan:
- Single event: evt pulse at cycle 2, destination model echoes req_tog back after 4 cycles → req_tog 0→1 after edge 3, busy 1 from 3, back to IDLE when ack_sync=1, pending returns to 0, no errors.
- Burst: evt high for 5 consecutive cycles, ack delay 3 → pending peaks at 4, req_tog flips exactly 5 times, each flip preceded by an ack match, ≥1 IDLE cycle between flips.
- Overflow: CNT_W=2, ack stalled, 6 evt pulses → pending saturates at 3 (one event already launched), ovf_err=1; after acks resume, exactly 4 total toggles observed.
- Timeout: TIMEOUT=8, ack never returns → tmo_err=1 at the 8th WAIT_ACK cycle, state ERROR, evt still increments pending; clr_err with ack mismatched stays in ERROR; after ack_sync matches, clr_err returns to IDLE and the next event launches.
- Boundary: ack match arriving on the exact timeout cycle → IDLE, tmo_err stays 0; clr_err on the same edge as an overflow → ovf_err=1.
- Reset mid-WAIT_ACK with pending=2 → next edge: req_tog=0, pending=0, busy=0, flags 0.
